// File: rtl/bitrun_stats.sv
// Per-packet statistics on a 1-bit stream: beat length, count of ones and
// longest run of ones, presented as one result word per packet.
module bitrun_stats #(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_valid,
    input  logic               i_sop,
    input  logic               i_eop,
    input  logic               inp,
    output logic               i_ready,
    input  logic               o_ready,
    output logic               o_valid,
    output logic [3*CNT_W-1:0] o_data,
    output logic               o_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] ones;
    logic [CNT_W-1:0] run;
    logic [CNT_W-1:0] max_run;
    logic             err;

    logic             acc;
    logic [CNT_W-1:0] first_val;
    logic [CNT_W-1:0] run_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_ONE;
    endfunction

    always_comb begin
        acc       = i_valid & (state != HOLD);
        first_val = {{(CNT_W-1){1'b0}}, inp};
        run_inc   = sat_inc(run);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            len     <= '0;
            ones    <= '0;
            run     <= '0;
            max_run <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc && i_sop) begin
                        len     <= CNT_ONE;
                        ones    <= first_val;
                        run     <= first_val;
                        max_run <= first_val;
                        err     <= 1'b0;
                        state   <= i_eop ? HOLD : PKT;
                    end
                end
                PKT: begin
                    if (acc) begin
                        if (i_sop) begin
                            // Missing eop: restart on this beat and flag the new packet.
                            len     <= CNT_ONE;
                            ones    <= first_val;
                            run     <= first_val;
                            max_run <= first_val;
                            err     <= 1'b1;
                        end else begin
                            len <= sat_inc(len);
                            if (inp) begin
                                ones <= sat_inc(ones);
                                run  <= run_inc;
                                if (run_inc > max_run)
                                    max_run <= run_inc;
                            end else begin
                                run <= '0;
                            end
                        end
                        if (i_eop)
                            state <= HOLD;
                    end
                end
                HOLD: begin
                    if (o_ready) begin
                        state <= IDLE;
                        err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign i_ready = (state != HOLD);
    assign o_valid = (state == HOLD);
    assign o_data  = {len, ones, max_run};
    assign o_err   = err;

endmodule

// File: tb/tb_bitrun_stats.sv
// Scoreboard bench for bitrun_stats: the same stream drives an 8-bit and a
// 4-bit counter instance; expected results come from the beat history.
module tb_bitrun_stats;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid, i_sop, i_eop, inp, o_ready;
    logic        i_ready8, o_valid8, o_err8;
    logic        i_ready4, o_valid4, o_err4;
    logic [23:0] o_data8;
    logic [11:0] o_data4;

    always #5 clk = ~clk;

    bitrun_stats #(.CNT_W(8)) u_dut8 (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_sop(i_sop), .i_eop(i_eop),
        .inp(inp), .i_ready(i_ready8), .o_ready(o_ready), .o_valid(o_valid8),
        .o_data(o_data8), .o_err(o_err8)
    );

    bitrun_stats #(.CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_sop(i_sop), .i_eop(i_eop),
        .inp(inp), .i_ready(i_ready4), .o_ready(o_ready), .o_valid(o_valid4),
        .o_data(o_data4), .o_err(o_err4)
    );

    typedef struct {
        int len;
        int ones;
        int maxr;
        bit err;
    } res_t;

    res_t exp_q[$];
    res_t mon_e;
    bit   m_bits[$];
    bit   m_in_pkt = 1'b0;
    bit   m_err    = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", tag, act, req);
    endtask

    function automatic int clamp(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    function automatic res_t summarize(input bit err);
        res_t r;
        int   cur;
        r.len = m_bits.size(); r.ones = 0; r.maxr = 0; r.err = err; cur = 0;
        foreach (m_bits[k]) begin
            if (m_bits[k]) begin
                r.ones++; cur++;
                if (cur > r.maxr) r.maxr = cur;
            end else begin
                cur = 0;
            end
        end
        return r;
    endfunction

    // Offer one beat until accepted, then fold it into the reference history.
    task automatic beat(input bit sop, input bit eop, input bit d);
        bit acc = 1'b0;
        i_valid = 1'b1; i_sop = sop; i_eop = eop; inp = d;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = i_ready8;
            @(posedge clk); #1;
        end
        i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0; inp = 1'b0;
        if (!acc) begin
            check("beat_accept_timeout", 0, 1);
        end else begin
            if (sop) begin
                m_err = m_in_pkt;
                m_in_pkt = 1'b1;
                m_bits.delete();
            end
            if (m_in_pkt) begin
                m_bits.push_back(d);
                if (eop) begin
                    exp_q.push_back(summarize(m_err));
                    m_in_pkt = 1'b0;
                end
            end
        end
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid8"}, o_valid8, 0);
        check({tag, "_data8"},  o_data8,  0);
        check({tag, "_err8"},   o_err8,   0);
        check({tag, "_valid4"}, o_valid4, 0);
        check({tag, "_data4"},  o_data4,  0);
        check({tag, "_err4"},   o_err4,   0);
    endtask

    always @(negedge clk) begin
        if (!reset && o_valid8 && o_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("len8",   o_data8[23:16], clamp(mon_e.len, 255));
                check("ones8",  o_data8[15:8],  clamp(mon_e.ones, 255));
                check("run8",   o_data8[7:0],   clamp(mon_e.maxr, 255));
                check("err8",   o_err8,         mon_e.err);
                check("valid4", o_valid4,       1);
                check("len4",   o_data4[11:8],  clamp(mon_e.len, 15));
                check("ones4",  o_data4[7:4],   clamp(mon_e.ones, 15));
                check("run4",   o_data4[3:0],   clamp(mon_e.maxr, 15));
                check("err4",   o_err4,         mon_e.err);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bit pkt1[7] = '{1, 1, 0, 1, 1, 1, 0};
        bit bp_bits[3] = '{1, 0, 1};
        reset = 1'b1; i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0; inp = 1'b0; o_ready = 1'b1;
        #12;
        check_zero_outputs("rst");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("iready_after_rst", i_ready8, 1);
        @(posedge clk); #1;

        // Basic packet and one-cycle result latency
        for (int i = 0; i < 7; i++) beat(i == 0, i == 6, pkt1[i]);
        @(negedge clk);
        check("basic_valid_next_cycle", o_valid8, 1);
        @(negedge clk);
        check("basic_valid_one_cycle", o_valid8, 0);
        @(posedge clk); #1;

        // Single-beat packets back to back
        beat(1, 1, 1);
        beat(1, 1, 0);
        gap(2);

        // Backpressure: result held, offered beat not consumed
        o_ready = 1'b0;
        for (int i = 0; i < 3; i++) beat(i == 0, i == 2, bp_bits[i]);
        i_valid = 1'b1; i_sop = 1'b1; i_eop = 1'b1; inp = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid",   o_valid8, 1);
            check("bp_iready8", i_ready8, 0);
            check("bp_iready4", i_ready4, 0);
            check("bp_data8", o_data8,
                  {8'(exp_q[0].len), 8'(exp_q[0].ones), 8'(exp_q[0].maxr)});
            check("bp_data4", o_data4,
                  {4'(exp_q[0].len), 4'(exp_q[0].ones), 4'(exp_q[0].maxr)});
        end
        @(posedge clk); #1;
        i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0; inp = 1'b0;
        o_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("iready_after_bp", i_ready8, 1);
        check("valid_after_bp",  o_valid8, 0);
        @(posedge clk); #1;

        // Framing error, then a clean packet
        beat(1, 0, 1); beat(0, 0, 1); beat(0, 0, 0);
        beat(1, 0, 1); beat(0, 1, 1);
        beat(1, 0, 0); beat(0, 1, 1);
        gap(2);

        // Saturation with an input gap mid-packet
        for (int i = 0; i < 20; i++) begin
            if (i == 10) gap(3);
            beat(i == 0, i == 19, 1);
        end
        gap(2);

        // Reset mid-packet, stray beats, then a short packet
        beat(1, 0, 1); beat(0, 0, 1);
        reset = 1'b1;
        m_in_pkt = 1'b0; m_bits.delete();
        #2;
        check_zero_outputs("rst_mid");
        @(posedge clk); #1;
        reset = 1'b0;
        beat(0, 0, 1); beat(0, 1, 1);
        beat(1, 0, 0); beat(0, 0, 1); beat(0, 1, 0);
        gap(2);

        // Reset while a result is pending
        o_ready = 1'b0;
        beat(1, 1, 1);
        @(negedge clk);
        check("hold_valid_before_rst", o_valid8, 1);
        reset = 1'b1;
        void'(exp_q.pop_back());
        #2;
        check_zero_outputs("rst_hold");
        @(posedge clk); #1;
        reset = 1'b0;
        o_ready = 1'b1;
        gap(4);

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
